// File: rtl/sirv_gnrl_dffpipe.sv
// Elastic multi-stage register pipeline with valid/ready on both sides.
// Empty stages always accept (bubble collapse); flush drops items, reset also restores data.
module sirv_gnrl_dffpipe #(
    parameter int              DW      = 32,
    parameter int              DEPTH   = 2,
    parameter logic [DW-1:0]   RST_VAL = {DW{1'b1}},
    parameter int              CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    input  logic          flush,
    output logic [CW-1:0] count
);

    logic [DEPTH-1:0] vld_r;
    logic [DW-1:0]    dat_r [DEPTH];
    logic [DEPTH-1:0] rdy_s;
    logic [DEPTH-1:0] vin_s;
    logic [DW-1:0]    din_s [DEPTH];
    logic [CW-1:0]    count_r;
    logic             in_xfer_s;
    logic             out_xfer_s;

    // Stage k is ready when it, or any stage downstream of it, is empty, or o_rdy is high.
    always_comb begin
        logic acc_s;
        acc_s = o_rdy;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            acc_s    = acc_s | ~vld_r[k];
            rdy_s[k] = acc_s;
        end
    end

    assign i_rdy      = rdy_s[0] & ~flush & ~rst;
    assign in_xfer_s  = i_vld & i_rdy;
    assign out_xfer_s = vld_r[DEPTH-1] & o_rdy;

    // Incoming valid/data for each stage: stage 0 from the upstream port, others from the previous stage.
    always_comb begin
        vin_s[0] = in_xfer_s;
        din_s[0] = i_dat;
        for (int k = 1; k < DEPTH; k++) begin
            vin_s[k] = vld_r[k-1];
            din_s[k] = dat_r[k-1];
        end
    end

    // Stage registers: reset restores data, flush only clears the valids.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_r[k] <= RST_VAL;
            end
        end else if (flush) begin
            vld_r <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (rdy_s[k]) begin
                    vld_r[k] <= vin_s[k];
                    if (vin_s[k]) begin
                        dat_r[k] <= din_s[k];
                    end
                end
            end
        end
    end

    // Occupancy counter tracks transfers; simultaneous in and out leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (flush) begin
            count_r <= '0;
        end else begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign o_vld = vld_r[DEPTH-1];
    assign o_dat = dat_r[DEPTH-1];
    assign count = count_r;

endmodule

// File: tb/tb_sirv_gnrl_dffpipe.sv
// Scoreboard bench: a 3-stage and a 1-stage instance, each with its own expected-data queue.
module tb_sirv_gnrl_dffpipe;

    logic       clk = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic       rst3, ivld3, irdy3, ovld3, ordy3, flush3;
    logic [7:0] idat3, odat3;
    logic [1:0] count3;
    logic       rst1, ivld1, irdy1, ovld1, ordy1, flush1;
    logic [7:0] idat1, odat1;
    logic [0:0] count1;

    logic [7:0] q3[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    sirv_gnrl_dffpipe #(.DW(8), .DEPTH(3), .RST_VAL(8'hA5)) u_dut3 (
        .clk(clk), .rst(rst3), .i_vld(ivld3), .i_rdy(irdy3), .i_dat(idat3),
        .o_vld(ovld3), .o_rdy(ordy3), .o_dat(odat3), .flush(flush3), .count(count3)
    );

    sirv_gnrl_dffpipe #(.DW(8), .DEPTH(1), .RST_VAL(8'h3C)) u_dut1 (
        .clk(clk), .rst(rst1), .i_vld(ivld1), .i_rdy(irdy1), .i_dat(idat1),
        .o_vld(ovld1), .o_rdy(ordy1), .o_dat(odat1), .flush(flush1), .count(count1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 3-stage instance, evaluated mid-cycle.
    always @(negedge clk) begin
        check_val("count3_occ", 32'(count3), 32'(q3.size()));
        if (rst3) begin
            q3.delete();
        end else begin
            if (ovld3 && ordy3) begin
                if (q3.size() == 0) check_val("out3_unexpected", 32'(odat3), 32'hFFFF_FFFF);
                else check_val("out3_data", 32'(odat3), 32'(q3.pop_front()));
            end
            if (ivld3 && irdy3) q3.push_back(idat3);
            if (flush3) q3.delete();
        end
    end

    // Scoreboard for the 1-stage instance.
    always @(negedge clk) begin
        check_val("count1_occ", 32'(count1), 32'(q1.size()));
        if (rst1) begin
            q1.delete();
        end else begin
            if (ovld1 && ordy1) begin
                if (q1.size() == 0) check_val("out1_unexpected", 32'(odat1), 32'hFFFF_FFFF);
                else check_val("out1_data", 32'(odat1), 32'(q1.pop_front()));
            end
            if (ivld1 && irdy1) q1.push_back(idat1);
            if (flush1) q1.delete();
        end
    end

    task automatic drain3();
        ivld3 = 1'b0;
        ordy3 = 1'b1;
        for (int n = 0; n < 20 && q3.size() > 0; n++) step();
        check_val("drain3_count", 32'(count3), 32'd0);
        check_val("drain3_ovld", 32'(ovld3), 32'd0);
    endtask

    task automatic drain1();
        ivld1 = 1'b0;
        ordy1 = 1'b1;
        for (int n = 0; n < 20 && q1.size() > 0; n++) step();
        check_val("drain1_count", 32'(count1), 32'd0);
    endtask

    initial begin
        logic [7:0] acc;
        logic [7:0] nxt1;
        rst3 = 1'b1; ivld3 = 1'b0; idat3 = 8'h00; ordy3 = 1'b0; flush3 = 1'b0;
        rst1 = 1'b1; ivld1 = 1'b0; idat1 = 8'h00; ordy1 = 1'b0; flush1 = 1'b0;

        // Reset: two cycles, i_rdy low throughout, then reset values.
        step();
        check_val("rst_irdy_low", 32'(irdy3), 32'd0);
        step();
        check_val("rst_irdy_low2", 32'(irdy3), 32'd0);
        rst3 = 1'b0;
        rst1 = 1'b0;
        #1;
        check_val("rst_ovld", 32'(ovld3), 32'd0);
        check_val("rst_odat", 32'(odat3), 32'hA5);
        check_val("rst_count", 32'(count3), 32'd0);
        check_val("rst_irdy_high", 32'(irdy3), 32'd1);
        check_val("rst1_odat", 32'(odat1), 32'h3C);

        // Back-to-back stream with o_rdy high.
        ordy3 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            idat3 = 8'(i);
            ivld3 = 1'b1;
            step();
            check_val("stream_ovld", 32'(ovld3), (i >= 3) ? 32'd1 : 32'd0);
            check_val("stream_count", 32'(count3), (i < 3) ? 32'(i) : 32'd3);
        end
        drain3();

        // Backpressure: only three of five pushes accepted.
        ordy3 = 1'b0;
        acc = 8'h00;
        for (int j = 0; j < 5; j++) begin
            ivld3 = 1'b1;
            idat3 = 8'h20 + acc;
            #1;
            check_val("bp_irdy", 32'(irdy3), (j < 3) ? 32'd1 : 32'd0);
            if (irdy3) acc = acc + 8'd1;
            step();
        end
        check_val("bp_count", 32'(count3), 32'd3);
        ordy3 = 1'b1;
        idat3 = 8'h20 + acc;
        #1;
        check_val("full_ordy_irdy", 32'(irdy3), 32'd1);
        step();
        ordy3 = 1'b0;
        ivld3 = 1'b0;
        check_val("bp_count_after", 32'(count3), 32'd3);
        check_val("bp_ovld_after", 32'(ovld3), 32'd1);
        drain3();

        // Bubble collapse: second push is not blocked by the stalled output.
        ordy3 = 1'b0;
        ivld3 = 1'b1;
        idat3 = 8'h40;
        #1;
        check_val("bub_irdy1", 32'(irdy3), 32'd1);
        step();
        ivld3 = 1'b0;
        step();
        step();
        ivld3 = 1'b1;
        idat3 = 8'h41;
        #1;
        check_val("bub_irdy2", 32'(irdy3), 32'd1);
        step();
        ivld3 = 1'b0;
        check_val("bub_count", 32'(count3), 32'd2);
        drain3();

        // Flush with two items in flight; o_dat keeps last drained value.
        ordy3 = 1'b0;
        ivld3 = 1'b1;
        idat3 = 8'h60;
        step();
        idat3 = 8'h61;
        step();
        check_val("fl_count_pre", 32'(count3), 32'd2);
        flush3 = 1'b1;
        idat3 = 8'h62;
        #1;
        check_val("fl_irdy", 32'(irdy3), 32'd0);
        step();
        flush3 = 1'b0;
        ivld3 = 1'b0;
        check_val("fl_ovld", 32'(ovld3), 32'd0);
        check_val("fl_count", 32'(count3), 32'd0);
        check_val("fl_odat", 32'(odat3), 32'h41);
        ordy3 = 1'b1;
        ivld3 = 1'b1;
        idat3 = 8'h70;
        step();
        ivld3 = 1'b0;
        check_val("fl_lat1", 32'(ovld3), 32'd0);
        step();
        check_val("fl_lat2", 32'(ovld3), 32'd0);
        step();
        check_val("fl_lat3", 32'(ovld3), 32'd1);
        check_val("fl_lat_dat", 32'(odat3), 32'h70);
        drain3();

        // Single stage: stream, then reset+flush collision mid-stream.
        nxt1 = 8'h50;
        for (int j = 0; j < 4; j++) begin
            ivld1 = 1'b1;
            idat1 = nxt1;
            ordy1 = 1'b1;
            #1;
            if (irdy1) nxt1 = nxt1 + 8'd1;
            step();
        end
        ordy1 = 1'b0;
        ivld1 = 1'b0;
        check_val("d1_ovld_pre", 32'(ovld1), 32'd1);
        rst1 = 1'b1;
        flush1 = 1'b1;
        ivld1 = 1'b1;
        idat1 = 8'h99;
        #1;
        check_val("d1_col_irdy", 32'(irdy1), 32'd0);
        step();
        rst1 = 1'b0;
        flush1 = 1'b0;
        ivld1 = 1'b0;
        check_val("d1_col_ovld", 32'(ovld1), 32'd0);
        check_val("d1_col_odat", 32'(odat1), 32'h3C);
        check_val("d1_col_count", 32'(count1), 32'd0);

        // Single-stage pass-through with toggling o_rdy.
        for (int j = 0; j < 12; j++) begin
            ivld1 = (j % 3 != 2);
            idat1 = nxt1;
            ordy1 = (j % 2 == 1);
            #1;
            if (irdy1 && ivld1) nxt1 = nxt1 + 8'd1;
            step();
        end
        drain1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
